// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@60, 40 MHz pixel clock) and derived window bounds.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
// Contents: per-axis sync/porch/active sizes, totals, first active column/row, counter width.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int H_SYNC   = 128;
    localparam int H_BACK   = 88;
    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 40;
    localparam int V_SYNC   = 4;
    localparam int V_BACK   = 23;
    localparam int V_ACTIVE = 600;
    localparam int V_FRONT  = 1;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;   // 1056
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;   // 628

    // First visible column/row in the 1-based counter space (217 / 28 by default).
    localparam int H_ACT_START = H_SYNC + H_BACK + 1;
    localparam int V_ACT_START = V_SYNC + V_BACK + 1;

    // Narrow an integer timing value to the counter width.
    function automatic logic [CNT_W-1:0] to_cnt(input int v);
        return v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle carrying the pixel enable into the timing generator and the timing outputs to consumers.
// Latency: n/a (wires only).
// Backpressure: none; en is the only flow control, it stalls the whole raster.
// master: timing generator (drives c1/c2/syncs/de/frame_start/frame_cnt, samples en).
// slave:  upstream/consumer side (drives en, samples the timing outputs).
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic             en;
    logic [CNT_W-1:0] c1;
    logic [CNT_W-1:0] c2;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             frame_start;
    logic [7:0]       frame_cnt;

    modport master (
        input  en,
        output c1, c2, hsync, vsync, de, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  c1, c2, hsync, vsync, de, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: 1..TOTAL wrap counter with registered sync and next-state active decode.
// Latency: cnt/sync change on the edge that consumes step; act_nxt is combinational (for the caller's register).
// Backpressure: counter holds while step is low.
// Ports: clk, rst_n (sync, active-low), step (advance), cnt, wrap (step at TOTAL), sync, act_nxt.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int   TOTAL     = H_TOTAL,
    parameter int   SYNC_LEN  = H_SYNC,
    parameter int   ACT_FIRST = H_ACT_START,
    parameter int   ACT_LAST  = H_ACT_START + H_ACTIVE - 1,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             sync,
    output logic             act_nxt
);

    localparam logic [CNT_W-1:0] ONE     = to_cnt(1);
    localparam logic [CNT_W-1:0] TOT_C   = to_cnt(TOTAL);
    localparam logic [CNT_W-1:0] SYNC_C  = to_cnt(SYNC_LEN);
    localparam logic [CNT_W-1:0] FIRST_C = to_cnt(ACT_FIRST);
    localparam logic [CNT_W-1:0] LAST_C  = to_cnt(ACT_LAST);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (step) begin
            cnt_nxt = (cnt == TOT_C) ? ONE : cnt + ONE;
        end
    end

    assign wrap    = step && (cnt == TOT_C);
    // Decoding the next value keeps registered outputs aligned with the counter they accompany.
    assign act_nxt = (cnt_nxt >= FIRST_C) && (cnt_nxt <= LAST_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= ONE;
            sync <= SYNC_POL;
        end else begin
            cnt  <= cnt_nxt;
            sync <= (cnt_nxt <= SYNC_C) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Screen timing source: 1-based column/row counters, hsync/vsync, de, frame_start strobe, frame_cnt.
// Latency: all outputs registered and consistent with the c1/c2 of the same cycle.
// Backpressure: bus.en low freezes every output; frame_start drops after one cycle.
// Ports: clk, rst_n (sync, active-low), bus (vga_sync_gen_if.master: en in; c1,c2,hsync,vsync,de,frame_start,frame_cnt out).
// Build option: define VGA_SYNC_FRAME_CNT_EN to count frames (mod 256); otherwise frame_cnt is constant 0.
// H_TOTAL and V_TOTAL must fit in 11 bits.
module vga_sync_gen #(
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BACK   = vga_pkg::H_BACK,
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FRONT  = vga_pkg::H_FRONT,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BACK   = vga_pkg::V_BACK,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FRONT  = vga_pkg::V_FRONT,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master bus
);
    import vga_pkg::*;

    localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    logic h_wrap, v_wrap;
    logic h_act_nxt, v_act_nxt;
    logic de_q, frame_start_q;

    vga_axis_cnt #(
        .TOTAL     (HT),
        .SYNC_LEN  (H_SYNC),
        .ACT_FIRST (H_SYNC + H_BACK + 1),
        .ACT_LAST  (H_SYNC + H_BACK + H_ACTIVE),
        .SYNC_POL  (SYNC_POL)
    ) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (bus.en),
        .cnt     (bus.c1),
        .wrap    (h_wrap),
        .sync    (bus.hsync),
        .act_nxt (h_act_nxt)
    );

    // Rows advance only on the pixel that wraps the line.
    vga_axis_cnt #(
        .TOTAL     (VT),
        .SYNC_LEN  (V_SYNC),
        .ACT_FIRST (V_SYNC + V_BACK + 1),
        .ACT_LAST  (V_SYNC + V_BACK + V_ACTIVE),
        .SYNC_POL  (SYNC_POL)
    ) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (h_wrap),
        .cnt     (bus.c2),
        .wrap    (v_wrap),
        .sync    (bus.vsync),
        .act_nxt (v_act_nxt)
    );

    // v_wrap already implies h_wrap and en, so it marks the (H_TOTAL, V_TOTAL) -> (1,1) step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= h_act_nxt && v_act_nxt;
            frame_start_q <= v_wrap;
        end
    end

    assign bus.de          = de_q;
    assign bus.frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Updates on the same edge that raises frame_start, so both are seen together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen with a reduced raster (17 x 10) so whole frames fit in the cycle budget.
// Reference model: plain integer raster position advanced by the counting rules; outputs derived from window arithmetic.
module tb_vga_sync_gen;

    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 5, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 17
    localparam int VT = VS + VB + VA + VF;   // 10
    localparam int FRAME = HT * VT;          // 170

`ifdef VGA_SYNC_FRAME_CNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_sync_gen_if bus();

    vga_sync_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference raster state
    int m_c1 = 1, m_c2 = 1, m_fc = 0;
    bit m_fs = 1'b0;

    function automatic bit exp_hs(input int c1);
        return (c1 <= HS);
    endfunction

    function automatic bit exp_vs(input int c2);
        return (c2 <= VS);
    endfunction

    function automatic bit exp_de(input int c1, input int c2);
        return (c1 > HS + HB) && (c1 <= HS + HB + HA) && (c2 > VS + VB) && (c2 <= VS + VB + VA);
    endfunction

    // Drive inputs, take one clock edge, advance the model, settle.
    task automatic tick(input bit en_v, input bit rst_v);
        bus.en = en_v;
        rst_n  = rst_v;
        @(posedge clk);
        if (!rst_v) begin
            m_c1 = 1; m_c2 = 1; m_fs = 1'b0; m_fc = 0;
        end else if (en_v) begin
            m_fs = (m_c1 == HT) && (m_c2 == VT);
            if (m_fs && FC_ON) m_fc = (m_fc + 1) % 256;
            if (m_c1 < HT) m_c1++;
            else begin
                m_c1 = 1;
                m_c2 = (m_c2 < VT) ? m_c2 + 1 : 1;
            end
        end else begin
            m_fs = 1'b0;
        end
        #1;
    endtask

    task automatic run_to(input int c1t, input int c2t);
        int n = 0;
        while (!(m_c1 == c1t && m_c2 == c2t) && n < 2 * FRAME) begin
            tick(1'b1, 1'b1);
            n++;
        end
        if (!(m_c1 == c1t && m_c2 == c2t)) begin
            total++; bad++;
            $display("FAIL run_to timeout target=(%0d,%0d)", c1t, c2t);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        total++; if (bus.c1 !== 11'd1) begin bad++; $display("FAIL reset_c1 got=%0d exp=1", bus.c1); end
        total++; if (bus.c2 !== 11'd1) begin bad++; $display("FAIL reset_c2 got=%0d exp=1", bus.c2); end
        total++; if (bus.hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", bus.hsync); end
        total++; if (bus.vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", bus.vsync); end
        total++; if (bus.de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", bus.de); end
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", bus.frame_start); end
        total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", bus.frame_cnt); end
        // first counted pixel after reset: no frame_start
        tick(1'b1, 1'b1);
        total++; if (bus.c1 !== 11'd2 || bus.frame_start !== 1'b0) begin
            bad++; $display("FAIL reset_release c1=%0d fs=%b exp c1=2 fs=0", bus.c1, bus.frame_start);
        end
    endtask

    task automatic test_line_wrap;
        run_to(HT, 5);
        total++; if (bus.c1 !== 11'(HT) || bus.c2 !== 11'd5 || bus.hsync !== 1'b0) begin
            bad++; $display("FAIL line_end c1=%0d c2=%0d hs=%b exp %0d,5,0", bus.c1, bus.c2, bus.hsync, HT);
        end
        tick(1'b1, 1'b1);
        total++; if (bus.c1 !== 11'd1 || bus.c2 !== 11'd6 || bus.hsync !== 1'b1) begin
            bad++; $display("FAIL line_wrap c1=%0d c2=%0d hs=%b exp 1,6,1", bus.c1, bus.c2, bus.hsync);
        end
        run_to(HS, 6);
        total++; if (bus.hsync !== 1'b1) begin bad++; $display("FAIL hsync_last got=%b exp=1", bus.hsync); end
        tick(1'b1, 1'b1);
        total++; if (bus.c1 !== 11'(HS + 1) || bus.hsync !== 1'b0) begin
            bad++; $display("FAIL hsync_fall c1=%0d hs=%b exp %0d,0", bus.c1, bus.hsync, HS + 1);
        end
    endtask

    task automatic test_de_window;
        int rises = 0, falls = 0;
        bit prev;
        run_to(1, VS + VB + 1);
        prev = bus.de;
        for (int i = 0; i < HT; i++) begin
            total++; if (bus.de !== exp_de(m_c1, m_c2)) begin
                bad++; $display("FAIL de_line c1=%0d c2=%0d got=%b exp=%b", m_c1, m_c2, bus.de, exp_de(m_c1, m_c2));
            end
            if (bus.de && !prev) begin
                rises++;
                total++; if (m_c1 != HS + HB + 1) begin bad++; $display("FAIL de_rise_col got=%0d exp=%0d", m_c1, HS + HB + 1); end
            end
            if (!bus.de && prev) begin
                falls++;
                total++; if (m_c1 != HS + HB + HA + 1) begin bad++; $display("FAIL de_fall_col got=%0d exp=%0d", m_c1, HS + HB + HA + 1); end
            end
            prev = bus.de;
            tick(1'b1, 1'b1);
        end
        total++; if (rises != 1 || falls != 1) begin bad++; $display("FAIL de_edges rises=%0d falls=%0d exp 1,1", rises, falls); end
        // last blank line before the window and the final frame line stay dark
        run_to(1, VS + VB);
        for (int i = 0; i < HT; i++) begin
            total++; if (bus.de !== 1'b0) begin bad++; $display("FAIL de_pre_line c1=%0d got=%b exp=0", m_c1, bus.de); end
            tick(1'b1, 1'b1);
        end
        run_to(1, VT);
        for (int i = 0; i < HT; i++) begin
            total++; if (bus.de !== 1'b0) begin bad++; $display("FAIL de_last_line c1=%0d got=%b exp=0", m_c1, bus.de); end
            tick(1'b1, 1'b1);
        end
    endtask

    task automatic test_frame_wrap;
        run_to(HT, VT);
        // stall exactly at the wrap point: no strobe
        tick(1'b0, 1'b1);
        total++; if (bus.frame_start !== 1'b0 || bus.c1 !== 11'(HT)) begin
            bad++; $display("FAIL wrap_stall fs=%b c1=%0d exp 0,%0d", bus.frame_start, bus.c1, HT);
        end
        tick(1'b1, 1'b1);
        total++; if (bus.c1 !== 11'd1 || bus.c2 !== 11'd1 || bus.frame_start !== 1'b1) begin
            bad++; $display("FAIL frame_wrap c1=%0d c2=%0d fs=%b exp 1,1,1", bus.c1, bus.c2, bus.frame_start);
        end
        total++; if (bus.frame_cnt !== 8'(m_fc) || bus.vsync !== 1'b1) begin
            bad++; $display("FAIL frame_wrap_fc fc=%0d vs=%b exp %0d,1", bus.frame_cnt, bus.vsync, m_fc);
        end
        tick(1'b1, 1'b1);
        total++; if (bus.frame_start !== 1'b0 || bus.c1 !== 11'd2) begin
            bad++; $display("FAIL fs_one_cycle fs=%b c1=%0d exp 0,2", bus.frame_start, bus.c1);
        end
    endtask

    task automatic test_en_stall;
        run_to(9, 5);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1);
            total++; if (bus.c1 !== 11'd9 || bus.c2 !== 11'd5 || bus.hsync !== exp_hs(9) ||
                         bus.vsync !== exp_vs(5) || bus.de !== exp_de(9, 5) || bus.frame_start !== 1'b0) begin
                bad++; $display("FAIL stall_hold c1=%0d c2=%0d hs=%b vs=%b de=%b fs=%b", bus.c1, bus.c2,
                                bus.hsync, bus.vsync, bus.de, bus.frame_start);
            end
        end
        tick(1'b1, 1'b1);
        total++; if (bus.c1 !== 11'd10 || bus.c2 !== 11'd5) begin
            bad++; $display("FAIL stall_resume c1=%0d c2=%0d exp 10,5", bus.c1, bus.c2);
        end
    endtask

    task automatic test_reset_mid;
        run_to(12, 7);
        tick(1'b1, 1'b0);
        total++; if (bus.c1 !== 11'd1 || bus.c2 !== 11'd1 || bus.hsync !== 1'b1 || bus.vsync !== 1'b1 ||
                     bus.de !== 1'b0 || bus.frame_start !== 1'b0 || bus.frame_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_mid c1=%0d c2=%0d hs=%b vs=%b de=%b fs=%b fc=%0d", bus.c1, bus.c2,
                            bus.hsync, bus.vsync, bus.de, bus.frame_start, bus.frame_cnt);
        end
        tick(1'b1, 1'b1);
        total++; if (bus.c1 !== 11'd2 || bus.frame_start !== 1'b0) begin
            bad++; $display("FAIL reset_mid_release c1=%0d fs=%b exp 2,0", bus.c1, bus.frame_start);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4000; i++) begin
            bit en_v = ($urandom_range(0, 3) != 0);
            bit rst_v = ($urandom_range(0, 999) != 0);
            if (i % 2 == 1 && i < 800) en_v = 1'b0;   // en toggling every cycle
            tick(en_v, rst_v);
            total++; if (bus.c1 !== 11'(m_c1) || bus.c2 !== 11'(m_c2) || bus.hsync !== exp_hs(m_c1) ||
                         bus.vsync !== exp_vs(m_c2) || bus.de !== exp_de(m_c1, m_c2) ||
                         bus.frame_start !== m_fs || bus.frame_cnt !== 8'(m_fc)) begin
                bad++; $display("FAIL random cyc=%0d c1=%0d/%0d c2=%0d/%0d hs=%b vs=%b de=%b fs=%b/%b fc=%0d/%0d",
                                i, bus.c1, m_c1, bus.c2, m_c2, bus.hsync, bus.vsync, bus.de,
                                bus.frame_start, m_fs, bus.frame_cnt, m_fc);
            end
        end
    endtask

    task automatic test_256_frames;
        int pulses = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 256 * FRAME; i++) begin
            tick(1'b1, 1'b1);
            if (bus.frame_start === 1'b1) pulses++;
        end
        total++; if (pulses != 256) begin bad++; $display("FAIL frame_pulses got=%0d exp=256", pulses); end
        total++; if (bus.c1 !== 11'd1 || bus.c2 !== 11'd1 || bus.frame_start !== 1'b1) begin
            bad++; $display("FAIL frames_end c1=%0d c2=%0d fs=%b exp 1,1,1", bus.c1, bus.c2, bus.frame_start);
        end
        total++; if (bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL frame_cnt_wrap got=%0d exp=0", bus.frame_cnt); end
        if (FC_ON) begin
            tick(1'b1, 1'b1);
            run_to(HT, VT);
            tick(1'b1, 1'b1);
            total++; if (bus.frame_cnt !== 8'd1) begin bad++; $display("FAIL frame_cnt_after_wrap got=%0d exp=1", bus.frame_cnt); end
        end
    endtask

    initial begin
        bus.en = 1'b0;
        test_reset();
        test_line_wrap();
        test_de_window();
        test_frame_wrap();
        test_en_stall();
        test_reset_mid();
        test_random();
        test_256_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing sequencer for the VGA display path. Generates the 1-based column/row counters (c1, c2) consumed by the vga_control window modules, plus hsync/vsync, an active-video flag and a frame-start strobe.
- Default timing is 800x600@60 (40 MHz pixel clock). Window modules decode their regions against the same constants, e.g. first active column = H_SYNC+H_BACK+1 = 217.
- Sits between the clock/reset block and all vga_control_* instances. It is the single timing source for the screen.

Parameters:
- H_SYNC, 128, hsync width in pixels
- H_BACK, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch
- V_SYNC, 4, vsync width in lines
- V_BACK, 23, vertical back porch
- V_ACTIVE, 600, visible lines
- V_FRONT, 1, vertical front porch
- SYNC_POL, 1'b1, active level of hsync/vsync

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  pixel enable; counters advance only when high
- c1  out  11  column counter, 1..H_TOTAL
- c2  out  11  row counter, 1..V_TOTAL
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video flag
- frame_start  out  1  one-cycle strobe at start of a new frame
- frame_cnt  out  8  frame counter (see Optional Feature)

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
  - Derived constants: H_TOTAL = sum of H_*, default 1056; V_TOTAL = sum of V_*, default 628. Both must fit in 11 bits.
  - Reset values: c1=1, c2=1, hsync=SYNC_POL, vsync=SYNC_POL, de=0, frame_start=0, frame_cnt=0.
- Counting (only on cycles with en=1):
  - If c1 < H_TOTAL, c1 increments by 1.
  - Otherwise c1 returns to 1. If c2 < V_TOTAL, c2 increments; otherwise c2 returns to 1.
  - With en=0, all outputs hold, and frame_start drops to 0 after one cycle.
- Output decode:
  - All outputs are registered. They are computed from next-state counter values, so in every cycle they are consistent with the c1/c2 presented in that same cycle (zero relative latency).
  - hsync = SYNC_POL when c1 <= H_SYNC, else ~SYNC_POL.
  - vsync = SYNC_POL when c2 <= V_SYNC, else ~SYNC_POL.
  - de = 1 iff H_SYNC+H_BACK < c1 <= H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK < c2 <= V_SYNC+V_BACK+V_ACTIVE. Default window: c1 217..1016, c2 28..627.
- frame_start:
  - Asserted for exactly one cycle when the counters move from (H_TOTAL, V_TOTAL) to (1,1).
  - Not asserted coming out of reset.
- Boundary cases:
  - Line wrap and frame wrap in the same cycle: c1 and c2 both return to 1, and frame_start=1.
  - Reset mid-frame: reset wins over en. All outputs return to reset values on the next edge.
  - en toggling every cycle: the counting sequence is identical to free-running, only stretched.

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined: frame_cnt increments by 1, mod 256, on every cycle in which frame_start is set; reset value is 0.
- Undefined: the frame_cnt port still exists but is tied to 8'd0, with no register inferred.

Decomposition:
- Shared package vga_pkg holds the default timing constants (H_/V_ values, H_TOTAL, V_TOTAL) and the derived window boundaries (H_ACT_START, V_ACT_START). vga_control_* decodes use the same package.
- One natural sub-module: vga_axis_cnt, a parameterised 1..TOTAL wrap counter with wrap output and sync/active decode. It is instanced twice: horizontal, then vertical, with the vertical instance enabled by the horizontal wrap.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with en=1 -> c1=1, c2=1, hsync=1, vsync=1, de=0, frame_start=0, frame_cnt=0.
- Line wrap: run to c1=1056, c2=5 -> next cycle c1=1, c2=6; hsync goes 0->1 at c1=1 and 1->0 at c1=129.
- de window on line c2=28: de rises at c1=217 and falls at c1=1017. On c2=27 and c2=628, de stays 0 for the whole line.
- Frame wrap: at c1=1056, c2=628 -> next cycle c1=1, c2=1, frame_start=1 for exactly one cycle, and frame_cnt increments when the macro is defined. After 256 frames, frame_cnt=0.
- en stall: drive en=0 for 10 cycles at c1=500 -> c1 holds at 500 and all outputs are unchanged. Resume -> c1=501.
- Reset mid-frame: assert rst_n=0 at c1=700, c2=300 -> next edge returns reset values, and no frame_start is produced.
